gpio_pwm_out: RTL



---
 rtl/gpio_pwm_pkg.sv | 36 +++
 rtl/gpio_pwm_chan.sv | 67 ++++++
 rtl/gpio_pwm_out.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gpio_pwm_pkg.sv
// Shared types and register map for the gpio_pwm_out driver.
// Holds the channel mode enum, the CHCFG word layout and address constants.
package gpio_pwm_pkg;

  typedef enum logic [1:0] {
    STATIC    = 2'd0,
    PWM       = 2'd1,
    BLINK     = 2'd2,
    PWM_BLINK = 2'd3
  } mode_t;

  // Bit-exact image of the 32-bit CHCFG register word.
  typedef struct packed {
    logic [15:0] half;
    logic [7:0]  duty;
    logic [3:0]  rsv;
    logic        level;
    logic        invert;
    mode_t       mode;
  } chcfg_t;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_CHBASE   = 2;

  // Bits of CHCFG that are stored; everything else reads back as 0.
  function automatic logic [31:0] chcfg_mask(input int cnt_w);
    logic [31:0] m;
    m = 32'hFFFF_000F;
    for (int i = 0; i < 8; i++) begin
      if (i < cnt_w) m[8+i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_pwm_chan.sv
// One output channel: blink counter, blink phase and mode mux.
// Ports: clk, reset, en_i, tick_i, clr_i, cfg fields, pwm_cnt_i -> raw_o.
module gpio_pwm_chan
  import gpio_pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             clr_i,
  input  mode_t            mode_i,
  input  logic             level_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic [15:0]      half_i,
  input  logic [CNT_W-1:0] pwm_cnt_i,
  output logic             raw_o
);

  logic [15:0] blk_q, blk_d;
  logic        ph_q, ph_d;
  logic        pwm_raw;

  // Disabled channels park at count 0, phase 1 so re-enable restarts cleanly.
  always_comb begin
    blk_d = blk_q;
    ph_d  = ph_q;
    if (!en_i || clr_i) begin
      blk_d = '0;
      ph_d  = 1'b1;
    end else if (tick_i) begin
      if (half_i == 16'd0) begin
        blk_d = '0;
        ph_d  = 1'b1;
      end else if (blk_q == half_i - 16'd1) begin
        blk_d = '0;
        ph_d  = ~ph_q;
      end else begin
        blk_d = blk_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q <= '0;
      ph_q  <= 1'b1;
    end else begin
      blk_q <= blk_d;
      ph_q  <= ph_d;
    end
  end

  assign pwm_raw = (pwm_cnt_i < duty_i);

  always_comb begin
    raw_o = 1'b0;
    unique case (mode_i)
      STATIC:    raw_o = level_i;
      PWM:       raw_o = pwm_raw;
      BLINK:     raw_o = ph_q;
      PWM_BLINK: raw_o = pwm_raw & ph_q;
    endcase
  end

endmodule

// File: rtl/gpio_pwm_out.sv
// NCHAN-channel LED/PMOD driver: static, PWM, blink, PWM-gated-by-blink.
// Ports: clk, reset, reg_* word register port, dout pin outputs.
// Option: GPIO_PWM_SYNC_UPDATE_EN shadows CHCFG until the next PWM wrap.
module gpio_pwm_out
  import gpio_pwm_pkg::*;
#(
  parameter int NCHAN  = 24,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_wr_en,
  input  logic              reg_rd_en,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_rd_valid,
  output logic [NCHAN-1:0]  dout
);

  localparam logic [31:0] CFG_MASK = chcfg_mask(CNT_W);

  logic             en_q;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NCHAN-1:0] dout_q, dout_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvld_q;

  chcfg_t           cfg_q  [NCHAN];
  chcfg_t           rd_cfg [NCHAN];
  chcfg_t           new_cfg;
  logic [NCHAN-1:0] ch_hit, ch_wr, cfg_clr, raw;
  logic             wr_ctrl, wr_pre, tick, wrap;

  assign wr_ctrl = reg_wr_en
                 & (reg_addr == ADDR_W'(ADDR_CTRL));
  assign wr_pre  = reg_wr_en
                 & (reg_addr == ADDR_W'(ADDR_PRESCALE));
  assign new_cfg = chcfg_t'(reg_wdata & CFG_MASK);

  for (genvar c = 0; c < NCHAN; c++) begin : g_hit
    assign ch_hit[c] = (reg_addr == ADDR_W'(ADDR_CHBASE + c));
    assign ch_wr[c]  = reg_wr_en & ch_hit[c];
  end

  // Tick is the last cycle of a prescaler period; wrap is the
  // tick on which pwm_cnt rolls over to 0.
  assign tick = en_q & (pre_cnt_q == pre_q);
  assign wrap = tick & (pwm_cnt_q == {CNT_W{1'b1}});

  always_comb begin
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    if (!en_q || wr_pre || tick) pre_cnt_d = '0;
    pwm_cnt_d = pwm_cnt_q;
    if (!en_q)     pwm_cnt_d = '0;
    else if (tick) pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
  end

`ifdef GPIO_PWM_SYNC_UPDATE_EN
  chcfg_t           shd_q [NCHAN];
  logic [NCHAN-1:0] dirty_q;

  // While disabled the write bypasses straight to the active set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCHAN; c++) begin
        shd_q[c] <= '0;
        cfg_q[c] <= '0;
      end
      dirty_q <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (ch_wr[c]) shd_q[c] <= new_cfg;
        if (!en_q)
          cfg_q[c] <= ch_wr[c] ? new_cfg : shd_q[c];
        else if (wrap)
          cfg_q[c] <= shd_q[c];
        if (ch_wr[c])
          dirty_q[c] <= 1'b1;
        else if (!en_q || wrap)
          dirty_q[c] <= 1'b0;
      end
    end
  end

  assign cfg_clr = {NCHAN{wrap}} & dirty_q;
  assign rd_cfg  = shd_q;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCHAN; c++) cfg_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (ch_wr[c]) cfg_q[c] <= new_cfg;
      end
    end
  end

  assign cfg_clr = ch_wr;
  assign rd_cfg  = cfg_q;
`endif

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    gpio_pwm_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en_q),
      .tick_i   (tick),
      .clr_i    (cfg_clr[c]),
      .mode_i   (cfg_q[c].mode),
      .level_i  (cfg_q[c].level),
      .duty_i   (cfg_q[c].duty[CNT_W-1:0]),
      .half_i   (cfg_q[c].half),
      .pwm_cnt_i(pwm_cnt_q),
      .raw_o    (raw[c])
    );
    assign dout_d[c] = en_q & (raw[c] ^ cfg_q[c].invert);
  end

  always_comb begin
    rdata_d = '0;
    if (reg_addr == ADDR_W'(ADDR_CTRL))
      rdata_d[0] = en_q;
    else if (reg_addr == ADDR_W'(ADDR_PRESCALE))
      rdata_d = 32'(pre_q);
    for (int c = 0; c < NCHAN; c++) begin
      if (ch_hit[c]) rdata_d = rd_cfg[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= 1'b0;
      pre_q     <= '0;
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      dout_q    <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
    end else begin
      if (wr_ctrl) en_q <= reg_wdata[0];
      if (wr_pre)  pre_q <= reg_wdata[PRE_W-1:0];
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      dout_q    <= dout_d;
      rvld_q    <= reg_rd_en;
      if (reg_rd_en) rdata_q <= rdata_d;
    end
  end

  assign dout         = dout_q;
  assign reg_rdata    = rdata_q;
  assign reg_rd_valid = rvld_q;

endmodule
